// File: rtl/nv_hs4_sync_rx_if.sv
// Handshake bundle between a 4-phase CDC source/consumer pair and the
// destination-side receive controller nv_hs4_sync_rx.
interface nv_hs4_sync_rx_if #(
    parameter int WIDTH = 32
);
    logic             req_s;
    logic [WIDTH-1:0] src_data;
    logic             ack;
    logic             dout_vld;
    logic             dout_rdy;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic             err_clr;
    logic             err_timeout;

    modport slave (
        input  req_s, src_data, dout_rdy, err_clr,
        output ack, dout_vld, dout, busy, err_timeout
    );

    modport master (
        output req_s, src_data, dout_rdy, err_clr,
        input  ack, dout_vld, dout, busy, err_timeout
    );
endinterface

// File: rtl/nv_hs4_sync_rx.sv
// Destination-side 4-phase req/ack receiver: captures source data on a synchronized
// request, presents it on valid/ready, returns ack and flags stuck handshakes.
module nv_hs4_sync_rx #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            clr_,
    nv_hs4_sync_rx_if.slave hs
);
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_VALID = 2'b01;
    localparam logic [1:0] ST_ACK   = 2'b10;

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic             ack_r;
    logic             dout_vld_r;
    logic             busy_r;
    logic             err_r;
    logic [WIDTH-1:0] dout_r;
    logic             capture_s;
    logic             enter_ack_s;
    logic             stuck_s;

    // Next-state decode; unused state code falls back to IDLE.
    always_comb begin
        state_nx_s  = state_r;
        capture_s   = 1'b0;
        enter_ack_s = 1'b0;
        stuck_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hs.req_s) begin
                    state_nx_s = ST_VALID;
                    capture_s  = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_VALID: begin
                if (hs.dout_rdy) begin
                    state_nx_s  = ST_ACK;
                    enter_ack_s = 1'b1;
                end else begin
                    state_nx_s = ST_VALID;
                end
            end
            ST_ACK: begin
                if (!hs.req_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_ACK;
                    stuck_s    = 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State plus outputs registered from the next state so they change on the same edge.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            state_r    <= ST_IDLE;
            ack_r      <= 1'b0;
            dout_vld_r <= 1'b0;
            busy_r     <= 1'b0;
            dout_r     <= '0;
        end else begin
            state_r    <= state_nx_s;
            ack_r      <= (state_nx_s == ST_ACK);
            dout_vld_r <= (state_nx_s == ST_VALID);
            busy_r     <= (state_nx_s != ST_IDLE);
            if (capture_s) begin
                dout_r <= hs.src_data;
            end
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
            // Error rises on the edge the counter steps to TIMEOUT-1.
            localparam logic [CW-1:0] SET_AT  = CW'((TIMEOUT > 1) ? (TIMEOUT - 2) : 0);

            logic [CW-1:0] cnt_r;

            // ACK-state dwell counter, saturating at TIMEOUT.
            always_ff @(posedge clk or negedge clr_) begin
                if (!clr_) begin
                    cnt_r <= '0;
                end else if (enter_ack_s) begin
                    cnt_r <= '0;
                end else if (stuck_s && (cnt_r != CNT_MAX)) begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end

            // Sticky timeout flag; a set on the same edge as err_clr takes priority.
            always_ff @(posedge clk or negedge clr_) begin
                if (!clr_) begin
                    err_r <= 1'b0;
                end else if (stuck_s && (cnt_r >= SET_AT)) begin
                    err_r <= 1'b1;
                end else if (hs.err_clr) begin
                    err_r <= 1'b0;
                end
            end
        end else begin : g_no_timer
            // Timer disabled: flag can only ever be cleared.
            always_ff @(posedge clk or negedge clr_) begin
                if (!clr_) begin
                    err_r <= 1'b0;
                end else if (hs.err_clr) begin
                    err_r <= 1'b0;
                end
            end
        end
    endgenerate

    assign hs.ack         = ack_r;
    assign hs.dout_vld    = dout_vld_r;
    assign hs.dout        = dout_r;
    assign hs.busy        = busy_r;
    assign hs.err_timeout = err_r;

endmodule

// File: tb/tb_nv_hs4_sync_rx.sv
// Directed self-checking bench for nv_hs4_sync_rx (WIDTH=32, TIMEOUT=8).
module tb_nv_hs4_sync_rx;
    logic clk;
    logic clr_;
    int   n_tests;
    int   n_fail;
    int   vld_pulses;
    logic vld_prev;

    nv_hs4_sync_rx_if #(.WIDTH(32)) hs ();

    nv_hs4_sync_rx #(.WIDTH(32), .TIMEOUT(8)) dut (
        .clk (clk),
        .clr_(clr_),
        .hs  (hs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges of dout_vld, sampled mid-cycle.
    always @(negedge clk) begin
        if (hs.dout_vld === 1'b1 && vld_prev !== 1'b1) begin
            vld_pulses <= vld_pulses + 1;
        end
        vld_prev <= hs.dout_vld;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int start;
        n_tests     = 0;
        n_fail      = 0;
        vld_pulses  = 0;
        clr_        = 1'b0;
        hs.req_s    = 1'b0;
        hs.src_data = 32'h0;
        hs.dout_rdy = 1'b0;
        hs.err_clr  = 1'b0;
        step();
        step();
        chk("rst_ack",  {31'd0, hs.ack},         32'd0);
        chk("rst_vld",  {31'd0, hs.dout_vld},    32'd0);
        chk("rst_busy", {31'd0, hs.busy},        32'd0);
        chk("rst_err",  {31'd0, hs.err_timeout}, 32'd0);
        chk("rst_dout", hs.dout,                 32'd0);
        clr_ = 1'b1;
        step();

        // 1 basic transfer
        hs.src_data = 32'hA5A5_0001;
        hs.dout_rdy = 1'b1;
        hs.req_s    = 1'b1;
        step();
        chk("basic_vld",  {31'd0, hs.dout_vld}, 32'd1);
        chk("basic_dout", hs.dout,              32'hA5A5_0001);
        chk("basic_ack0", {31'd0, hs.ack},      32'd0);
        chk("basic_busy", {31'd0, hs.busy},     32'd1);
        step();
        chk("basic_ack1", {31'd0, hs.ack},      32'd1);
        chk("basic_vld0", {31'd0, hs.dout_vld}, 32'd0);
        hs.req_s = 1'b0;
        step();
        chk("basic_ackf", {31'd0, hs.ack},      32'd0);
        chk("basic_idle", {31'd0, hs.busy},     32'd0);

        // 2 backpressure
        hs.dout_rdy = 1'b0;
        hs.src_data = 32'h1111_2222;
        hs.req_s    = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            if (i == 5) hs.src_data = 32'hDEAD_BEEF;
            step();
            chk("bp_vld",  {31'd0, hs.dout_vld}, 32'd1);
            chk("bp_ack",  {31'd0, hs.ack},      32'd0);
            chk("bp_dout", hs.dout,              32'h1111_2222);
        end
        hs.dout_rdy = 1'b1;
        step();
        chk("bp_ack1", {31'd0, hs.ack},      32'd1);
        chk("bp_vld0", {31'd0, hs.dout_vld}, 32'd0);
        hs.req_s = 1'b0;
        step();
        chk("bp_ackf", {31'd0, hs.ack}, 32'd0);

        // 3 timeout (TIMEOUT=8)
        hs.src_data = 32'h0000_0003;
        hs.req_s    = 1'b1;
        step();
        step();
        chk("to_ack", {31'd0, hs.ack}, 32'd1);
        for (int i = 0; i < 6; i++) step();
        chk("to_err_7th", {31'd0, hs.err_timeout}, 32'd0);
        step();
        chk("to_err_8th", {31'd0, hs.err_timeout}, 32'd1);
        chk("to_ack_hold", {31'd0, hs.ack},        32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("to_ack_wait", {31'd0, hs.ack},        32'd1);
        hs.err_clr = 1'b1;
        step();
        hs.err_clr = 1'b0;
        chk("to_set_wins", {31'd0, hs.err_timeout}, 32'd1);
        hs.req_s = 1'b0;
        step();
        chk("to_idle_ack",  {31'd0, hs.ack},         32'd0);
        chk("to_idle_busy", {31'd0, hs.busy},        32'd0);
        chk("to_sticky",    {31'd0, hs.err_timeout}, 32'd1);
        hs.err_clr = 1'b1;
        step();
        hs.err_clr = 1'b0;
        chk("to_cleared", {31'd0, hs.err_timeout}, 32'd0);

        // 4 back-to-back transfers
        start = vld_pulses;
        hs.dout_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            hs.src_data = i;
            hs.req_s    = 1'b1;
            n = 0;
            while (hs.dout_vld !== 1'b1 && n < 20) begin step(); n++; end
            chk("b2b_vld",  {31'd0, hs.dout_vld}, 32'd1);
            chk("b2b_dout", hs.dout,              i);
            n = 0;
            while (hs.ack !== 1'b1 && n < 20) begin step(); n++; end
            chk("b2b_ack", {31'd0, hs.ack}, 32'd1);
            hs.req_s = 1'b0;
            n = 0;
            while (hs.ack !== 1'b0 && n < 20) begin step(); n++; end
            chk("b2b_ackf", {31'd0, hs.ack}, 32'd0);
        end
        step();
        chk("b2b_pulses", vld_pulses - start, 32'd16);

        // 5 reset mid-op: VALID, then ACK
        hs.dout_rdy = 1'b0;
        hs.src_data = 32'h0000_0055;
        hs.req_s    = 1'b1;
        step();
        chk("rv_vld", {31'd0, hs.dout_vld}, 32'd1);
        clr_ = 1'b0;
        #1;
        chk("rv_vld0",  {31'd0, hs.dout_vld}, 32'd0);
        chk("rv_busy0", {31'd0, hs.busy},     32'd0);
        chk("rv_dout0", hs.dout,              32'd0);
        hs.src_data = 32'h0000_0066;
        #1;
        clr_ = 1'b1;
        step();
        chk("rv_recap_vld",  {31'd0, hs.dout_vld}, 32'd1);
        chk("rv_recap_dout", hs.dout,              32'h0000_0066);
        hs.dout_rdy = 1'b1;
        step();
        chk("ra_ack", {31'd0, hs.ack}, 32'd1);
        clr_ = 1'b0;
        #1;
        chk("ra_ack0",  {31'd0, hs.ack},      32'd0);
        chk("ra_busy0", {31'd0, hs.busy},     32'd0);
        chk("ra_vld0",  {31'd0, hs.dout_vld}, 32'd0);
        hs.src_data = 32'h0000_0077;
        #1;
        clr_ = 1'b1;
        step();
        chk("ra_recap_vld",  {31'd0, hs.dout_vld}, 32'd1);
        chk("ra_recap_dout", hs.dout,              32'h0000_0077);
        step();
        hs.req_s = 1'b0;
        step();
        chk("ra_idle", {31'd0, hs.busy}, 32'd0);

        // 6 abort: req drops while VALID
        hs.dout_rdy = 1'b0;
        hs.src_data = 32'h0000_0ABC;
        hs.req_s    = 1'b1;
        step();
        hs.req_s = 1'b0;
        step();
        chk("ab_vld",  {31'd0, hs.dout_vld}, 32'd1);
        chk("ab_dout", hs.dout,              32'h0000_0ABC);
        hs.dout_rdy = 1'b1;
        step();
        chk("ab_ack1", {31'd0, hs.ack},      32'd1);
        chk("ab_vld0", {31'd0, hs.dout_vld}, 32'd0);
        step();
        chk("ab_ack0", {31'd0, hs.ack},  32'd0);
        chk("ab_idle", {31'd0, hs.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
